// File: rtl/packet_buffer_bank_pkg.sv
// Shared constants and entry helpers for the four-lane packet buffer bank.
package pkt_buf_pkg;

  localparam int unsigned ENTRY_W     = 3;
  localparam int unsigned DEPTH       = 5;
  localparam int unsigned BUS_W       = 18;
  localparam int unsigned VALID_OFS   = 0;
  localparam int unsigned PAYLOAD_OFS = 1;
  localparam int unsigned PAYLOAD_W   = 2;
  localparam int unsigned OCC_W       = 3;
  localparam int unsigned NUM_LANES   = 4;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  typedef logic [ENTRY_W-1:0] entry_t;

  function automatic entry_t make_entry(input logic [PAYLOAD_W-1:0] payload);
    entry_t e;
    e = '0;
    e[VALID_OFS] = 1'b1;
    e[PAYLOAD_OFS +: PAYLOAD_W] = payload;
    return e;
  endfunction

endpackage

// File: rtl/packet_buffer_bank_lane.sv
// One compacted queue: oldest entry at slot 0, unused slots held at zero.
module packet_lane
  import pkt_buf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic                 pop,
  output logic [BUS_W-1:0]     bus,
  output logic                 full,
  output logic                 reject
);

  entry_t           slots   [DEPTH];
  entry_t           slots_n [DEPTH];
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] occ_n;
  logic             pop_ok;
  logic             push_ok;

  // Pop is applied first so a full lane can accept a push in the same cycle.
  always_comb begin
    pop_ok  = pop && (occ != '0);
    occ_d   = occ - OCC_W'(pop_ok);
    push_ok = push && (occ_d < OCC_W'(DEPTH));
    reject  = push && !push_ok;
    occ_n   = occ_d + OCC_W'(push_ok);
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slots_n[k] = slots[k];
    end
    if (pop_ok) begin
      for (int unsigned k = 0; k < DEPTH - 1; k++) begin
        slots_n[k] = slots[k+1];
      end
      slots_n[DEPTH-1] = '0;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (push_ok && (occ_d == OCC_W'(k))) begin
        slots_n[k] = make_entry(payload);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slots <= '{default: '0};
      occ   <= '0;
      full  <= 1'b0;
    end else begin
      slots <= slots_n;
      occ   <= occ_n;
      full  <= (occ_n == OCC_W'(DEPTH));
    end
  end

  // Top slot of the bus is reserved and tied to zero.
  always_comb begin
    bus = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      bus[k*ENTRY_W +: ENTRY_W] = slots[k];
    end
  end

endmodule

// File: rtl/packet_buffer_bank.sv
// Four-lane packet buffer bank: destination decode, per-lane queues, drop tracking.
module packet_buffer_bank
  import pkt_buf_pkg::*;
#(
  parameter int unsigned DCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_dest,
  input  logic [1:0]        wr_payload,
  input  logic [3:0]        rd_en,
  output logic [17:0]       buffer1_o,
  output logic [17:0]       buffer2_o,
  output logic [17:0]       buffer3_o,
  output logic [17:0]       buffer4_o,
  output logic [3:0]        head_valid,
  output logic [7:0]        head_data,
  output logic [3:0]        full,
  output logic              drop,
  output logic [DCNT_W-1:0] drop_cnt
);

  logic [BUS_W-1:0]     lane_bus [NUM_LANES];
  logic [NUM_LANES-1:0] lane_push;
  logic [NUM_LANES-1:0] lane_reject;

  always_comb begin
    lane_push = '0;
    lane_push[wr_dest] = wr_en;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    packet_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .push    (lane_push[i]),
      .payload (wr_payload),
      .pop     (rd_en[i]),
      .bus     (lane_bus[i]),
      .full    (full[i]),
      .reject  (lane_reject[i])
    );
  end

  assign buffer1_o = lane_bus[LANE0];
  assign buffer2_o = lane_bus[LANE1];
  assign buffer3_o = lane_bus[LANE2];
  assign buffer4_o = lane_bus[LANE3];

  always_comb begin
    head_valid = '0;
    head_data  = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      head_valid[i]         = lane_bus[i][VALID_OFS];
      head_data[2*i +: 2]   = lane_bus[i][PAYLOAD_OFS +: PAYLOAD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      drop <= |lane_reject;
      if ((|lane_reject) && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_packet_buffer_bank.sv
// Scoreboarded bench for packet_buffer_bank: behavioural queue model plus directed checks.
module tb_packet_buffer_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_dest;
  logic [1:0]  wr_payload;
  logic [3:0]  rd_en;
  logic [17:0] buffer1_o, buffer2_o, buffer3_o, buffer4_o;
  logic [3:0]  head_valid;
  logic [7:0]  head_data;
  logic [3:0]  full;
  logic        drop;
  logic [7:0]  drop_cnt;

  packet_buffer_bank #(.DCNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_dest    (wr_dest),
    .wr_payload (wr_payload),
    .rd_en      (rd_en),
    .buffer1_o  (buffer1_o),
    .buffer2_o  (buffer2_o),
    .buffer3_o  (buffer3_o),
    .buffer4_o  (buffer4_o),
    .head_valid (head_valid),
    .head_data  (head_data),
    .full       (full),
    .drop       (drop),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][17:0] bus;
    logic [3:0][2:0]  occ;
    logic [3:0]       hv;
    logic [7:0]       hd;
    logic [3:0]       full;
    logic             drop;
    logic [7:0]       cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural reference: plain per-lane payload lists with explicit occupancy.
  int         m_occ [4];
  logic [1:0] m_pay [4][5];
  logic       m_drop;
  int         m_cnt;

  logic [3:0][17:0] dbus;
  assign dbus = {buffer4_o, buffer3_o, buffer2_o, buffer1_o};

  task automatic chk(input string name, input logic [17:0] got, input logic [17:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic exp_t model_step(input logic r, input logic w, input logic [1:0] d,
                                      input logic [1:0] p, input logic [3:0] rd);
    exp_t e;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_occ[i] = 0;
        for (int j = 0; j < 5; j++) m_pay[i][j] = 2'b00;
      end
      m_drop = 1'b0;
      m_cnt  = 0;
    end else begin
      m_drop = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (rd[i] && m_occ[i] > 0) begin
          for (int j = 0; j < 4; j++) m_pay[i][j] = m_pay[i][j+1];
          m_pay[i][4] = 2'b00;
          m_occ[i]--;
        end
      end
      if (w) begin
        if (m_occ[d] < 5) begin
          m_pay[d][m_occ[d]] = p;
          m_occ[d]++;
        end else begin
          m_drop = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
    e = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < m_occ[i]; j++) e.bus[i][3*j +: 3] = {m_pay[i][j], 1'b1};
      e.occ[i]      = 3'(m_occ[i]);
      e.hv[i]       = (m_occ[i] > 0);
      e.hd[2*i +: 2] = (m_occ[i] > 0) ? m_pay[i][0] : 2'b00;
      e.full[i]     = (m_occ[i] == 5);
    end
    e.drop = m_drop;
    e.cnt  = 8'(m_cnt);
    return e;
  endfunction

  task automatic cyc(input logic r, input logic w, input logic [1:0] d,
                     input logic [1:0] p, input logic [3:0] rd);
    @(negedge clk);
    rst = r; wr_en = w; wr_dest = d; wr_payload = p; rd_en = rd;
    q.push_back(model_step(r, w, d, p, rd));
    @(posedge clk);
  endtask

  // Monitor: every edge with a pending expectation, compare the full registered output set.
  initial begin
    exp_t e;
    int   pc;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("bus%0d", i + 1), dbus[i], e.bus[i]);
          pc = 0;
          for (int j = 0; j < 6; j++) pc += int'(dbus[i][3*j]);
          chk($sformatf("occ_inv%0d", i + 1), 18'(pc), 18'(e.occ[i]));
          chk($sformatf("bit15_%0d", i + 1), 18'(dbus[i][15]), 18'd0);
        end
        chk("head_valid", 18'(head_valid), 18'(e.hv));
        chk("head_data",  18'(head_data),  18'(e.hd));
        chk("full",       18'(full),       18'(e.full));
        chk("drop",       18'(drop),       18'(e.drop));
        chk("drop_cnt",   18'(drop_cnt),   18'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_dest = 2'd0; wr_payload = 2'd0; rd_en = 4'd0;
    cyc(1, 0, 0, 0, 4'b0000);
    cyc(1, 0, 0, 0, 4'b0000);

    // Reset in the middle of traffic on lane 2.
    cyc(0, 1, 2, 1, 4'b0000);
    cyc(0, 1, 2, 2, 4'b0000);
    cyc(0, 1, 2, 3, 4'b0000);
    cyc(1, 1, 2, 3, 4'b0100);
    #2;
    chk("rst_bus3", buffer3_o, 18'd0);
    chk("rst_cnt", 18'(drop_cnt), 18'd0);

    // Lane 0: payloads 1,2,3.
    cyc(0, 1, 0, 1, 4'b0000);
    cyc(0, 1, 0, 2, 4'b0000);
    cyc(0, 1, 0, 3, 4'b0000);
    #2;
    chk("lane0_bus", buffer1_o, 18'b000_000_000_111_101_011);
    chk("lane0_head", 18'(head_data[1:0]), 18'd1);

    // Multi-lane: pop empty lane 3, pop lanes 0 and 2, push lane 1 together.
    cyc(0, 1, 2, 3, 4'b0000);
    cyc(0, 1, 2, 0, 4'b0000);
    cyc(0, 1, 1, 2, 4'b1101);
    #2;
    chk("multi_bus1", buffer1_o, 18'b000_000_000_000_111_101);
    chk("multi_bus2", buffer2_o, 18'b000_000_000_000_000_101);
    chk("multi_bus3", buffer3_o, 18'b000_000_000_000_000_001);
    chk("multi_bus4", buffer4_o, 18'd0);
    chk("multi_drop", 18'(drop), 18'd0);

    // Lane 1 cleared, then filled with 0,1,2,3,0 and overfilled once.
    cyc(0, 0, 0, 0, 4'b0010);
    cyc(0, 1, 1, 0, 4'b0000);
    cyc(0, 1, 1, 1, 4'b0000);
    cyc(0, 1, 1, 2, 4'b0000);
    cyc(0, 1, 1, 3, 4'b0000);
    cyc(0, 1, 1, 0, 4'b0000);
    cyc(0, 1, 1, 3, 4'b0000);
    #2;
    chk("ovf_full", 18'(full[1]), 18'd1);
    chk("ovf_drop", 18'(drop), 18'd1);
    chk("ovf_cnt", 18'(drop_cnt), 18'd1);
    chk("ovf_bus2", buffer2_o, 18'b000_001_111_101_011_001);
    cyc(0, 0, 0, 0, 4'b0000);
    #2;
    chk("drop_pulse_end", 18'(drop), 18'd0);

    // Full lane 1: push and pop in one cycle.
    cyc(0, 1, 1, 0, 4'b0010);
    #2;
    chk("pp_drop", 18'(drop), 18'd0);
    chk("pp_bus2", buffer2_o, 18'b000_001_001_111_101_011);
    chk("pp_full", 18'(full[1]), 18'd1);
    chk("pp_cnt", 18'(drop_cnt), 18'd1);

    // Saturate the drop counter.
    for (int n = 0; n < 260; n++) cyc(0, 1, 1, 2'(n), 4'b0000);
    #2;
    chk("sat_cnt", 18'(drop_cnt), 18'd255);
    chk("sat_bus2", buffer2_o, 18'b000_001_001_111_101_011);

    // Random soak.
    for (int n = 0; n < 400; n++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
    end
    cyc(0, 0, 0, 0, 4'b0000);
    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
